// File: rtl/seven_segment_scan_decoder.sv
// Receive side of a multiplexed active-low seven-segment bus: waits for a
// stable single-digit pattern, decodes it to hex, and reports frame completion.
module seven_segment_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  anode_n,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  digit_error,
  output logic        frame_done
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  // Returns {legal, value} for an active-low {g..a} pattern.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // Returns {exactly_one_active, index_of_active_digit}.
  function automatic logic [2:0] active_digit(input logic [3:0] an);
    logic [2:0] r;
    case (an)
      4'b1110: r = {1'b1, 2'd0};
      4'b1101: r = {1'b1, 2'd1};
      4'b1011: r = {1'b1, 2'd2};
      4'b0111: r = {1'b1, 2'd3};
      default: r = {1'b0, 2'd0};
    endcase
    return r;
  endfunction

  logic [6:0]  s_seg_q, s_seg_d;
  logic [3:0]  s_an_q, s_an_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  error_q, error_d;
  logic [3:0]  mask_q, mask_d;
  logic        frame_done_q, frame_done_d;

  logic [2:0]  act;
  logic [4:0]  glyph;
  logic        changed;
  logic        capture;
  logic [3:0]  sel;
  logic [3:0]  mask_or;

  always_comb begin
    s_seg_d      = s_seg_q;
    s_an_d       = s_an_q;
    cnt_d        = cnt_q;
    digits_d     = digits_q;
    valid_d      = valid_q;
    error_d      = error_q;
    mask_d       = mask_q;
    frame_done_d = 1'b0;

    act     = active_digit(anode_n);
    glyph   = decode_glyph(seg_n);
    changed = ({seg_n, anode_n} != {s_seg_q, s_an_q});
    capture = 1'b0;
    sel     = 4'b0001 << act[1:0];
    mask_or = mask_q;

    if (changed) begin
      s_seg_d = seg_n;
      s_an_d  = anode_n;
      cnt_d   = act[2] ? 8'd1 : 8'd0;
    end else if (act[2]) begin
      // Capture happens only on the step into saturation, never while parked there.
      if (cnt_q < STABLE_MAX) begin
        cnt_d   = cnt_q + 8'd1;
        capture = (cnt_q == (STABLE_MAX - 8'd1));
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = 8'd0;
    end

    if (capture) begin
      if (glyph[4]) begin
        digits_d[{act[1:0], 2'b00} +: 4] = glyph[3:0];
        valid_d = valid_q | sel;
        error_d = error_q & ~sel;
      end else begin
        valid_d = valid_q & ~sel;
        error_d = error_q | sel;
      end
      mask_or = mask_q | sel;
      if (mask_or == 4'hF) begin
        mask_d       = 4'h0;
        frame_done_d = 1'b1;
      end else begin
        mask_d = mask_or;
      end
    end else begin
      mask_d = mask_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_seg_q      <= 7'h7F;
      s_an_q       <= 4'hF;
      cnt_q        <= 8'd0;
      digits_q     <= 16'h0000;
      valid_q      <= 4'b0000;
      error_q      <= 4'b0000;
      mask_q       <= 4'b0000;
      frame_done_q <= 1'b0;
    end else begin
      s_seg_q      <= s_seg_d;
      s_an_q       <= s_an_d;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
      mask_q       <= mask_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_error = error_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for seven_segment_scan_decoder with STABLE_CYCLES = 4.
module tb_seven_segment_scan_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  seg_n;
  logic [3:0]  anode_n;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_error;
  logic        frame_done;

  int tests  = 0;
  int failed = 0;
  int fd_cnt = 0;

  seven_segment_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg_n       (seg_n),
    .anode_n     (anode_n),
    .digits      (digits),
    .digit_valid (digit_valid),
    .digit_error (digit_error),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold one bus pattern for n edges, sampling 1 time unit after each edge.
  task automatic run(input logic [6:0] seg, input logic [3:0] an, input int n);
    seg_n   = seg;
    anode_n = an;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) fd_cnt++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    run(7'h7F, 4'hF, 2);
    check("rst_digits", digits, 16'h0000);
    check("rst_valid", {12'h0, digit_valid}, 16'h0000);
    check("rst_error", {12'h0, digit_error}, 16'h0000);
    check("rst_fd", {15'h0, frame_done}, 16'h0000);

    // single digit 3 on digit 0, latency and no re-capture
    reset_n = 1'b1;
    fd_cnt  = 0;
    run(7'h30, 4'b1110, 3);
    check("d0_early_valid", {12'h0, digit_valid}, 16'h0000);
    run(7'h30, 4'b1110, 1);
    check("d0_digits", digits, 16'h0003);
    check("d0_valid", {12'h0, digit_valid}, 16'h0001);
    check("d0_error", {12'h0, digit_error}, 16'h0000);
    run(7'h30, 4'b1110, 10);
    check("d0_hold_digits", digits, 16'h0003);
    check("d0_hold_valid", {12'h0, digit_valid}, 16'h0001);
    check("d0_hold_fd", 16'(fd_cnt), 16'd0);

    // illegal blank pattern on digit 1
    run(7'h7F, 4'b1101, 4);
    check("ill1_error", {12'h0, digit_error}, 16'h0002);
    check("ill1_valid", {12'h0, digit_valid}, 16'h0001);
    check("ill1_digits", digits, 16'h0003);

    // full scan 3 C 9 5
    run(7'h30, 4'b1110, 4);
    run(7'h46, 4'b1101, 4);
    run(7'h10, 4'b1011, 4);
    check("scan_fd_before", 16'(fd_cnt), 16'd0);
    run(7'h12, 4'b0111, 4);
    check("scan_fd_pulse", {15'h0, frame_done}, 16'h0001);
    check("scan_digits", digits, 16'h59C3);
    check("scan_valid", {12'h0, digit_valid}, 16'h000F);
    check("scan_error", {12'h0, digit_error}, 16'h0000);
    run(7'h12, 4'b0111, 1);
    check("scan_fd_drop", {15'h0, frame_done}, 16'h0000);
    check("scan_fd_count", 16'(fd_cnt), 16'd1);

    // unstable segments, then overlapping anodes: nothing captured
    fd_cnt = 0;
    for (int i = 0; i < 6; i++) run((i % 2 == 0) ? 7'h40 : 7'h79, 4'b1011, 3);
    check("toggle_digits", digits, 16'h59C3);
    check("toggle_valid", {12'h0, digit_valid}, 16'h000F);
    run(7'h40, 4'b1100, 20);
    check("overlap_digits", digits, 16'h59C3);
    check("overlap_valid", {12'h0, digit_valid}, 16'h000F);
    check("overlap_error", {12'h0, digit_error}, 16'h0000);
    check("overlap_fd", 16'(fd_cnt), 16'd0);

    // digit 0 re-captured twice before the rest of the frame
    run(7'h79, 4'b1110, 4);
    run(7'h7F, 4'hF, 1);
    run(7'h24, 4'b1110, 4);
    check("recap_digits", digits, 16'h59C2);
    run(7'h40, 4'b1101, 4);
    run(7'h0E, 4'b1011, 4);
    check("recap_fd_before", 16'(fd_cnt), 16'd0);
    run(7'h03, 4'b0111, 4);
    check("recap_fd_pulse", {15'h0, frame_done}, 16'h0001);
    check("recap_digits_full", digits, 16'hBF02);
    run(7'h03, 4'b0111, 1);
    check("recap_fd_count", 16'(fd_cnt), 16'd1);

    // illegal glyph keeps the old nibble of digit 2
    run(7'h7F, 4'b1011, 4);
    check("ill2_digits", digits, 16'hBF02);
    check("ill2_valid", {12'h0, digit_valid}, 16'h000B);
    check("ill2_error", {12'h0, digit_error}, 16'h0004);

    // reset aborts a partial count
    run(7'h19, 4'b1110, 3);
    reset_n = 1'b0;
    run(7'h19, 4'b1110, 1);
    check("mid_rst_digits", digits, 16'h0000);
    check("mid_rst_valid", {12'h0, digit_valid}, 16'h0000);
    check("mid_rst_error", {12'h0, digit_error}, 16'h0000);
    reset_n = 1'b1;
    run(7'h19, 4'b1110, 3);
    check("post_rst_early", {12'h0, digit_valid}, 16'h0000);
    run(7'h19, 4'b1110, 1);
    check("post_rst_digits", digits, 16'h0004);
    check("post_rst_valid", {12'h0, digit_valid}, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
